// File: rtl/mem_multi_port_if.sv
// Request/response bundle for mem_multi_port: NUM_CH packed valid/ready request
// channels plus per-channel read-return and error pulses.
interface mem_multi_port_if #(
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 6,
   parameter int NUM_CH     = 2
);
   logic [NUM_CH-1:0]            valid_i;
   logic [NUM_CH-1:0]            wr_rd_i;
   logic [NUM_CH*ADDR_WIDTH-1:0] addr_i;
   logic [NUM_CH*WIDTH-1:0]      wr_data_i;
   logic [NUM_CH*(WIDTH/8)-1:0]  be_i;
   logic [NUM_CH-1:0]            ready_o;
   logic [NUM_CH-1:0]            rd_valid_o;
   logic [NUM_CH*WIDTH-1:0]      rd_data_o;
   logic [NUM_CH-1:0]            err_o;

   modport master (
      output valid_i, wr_rd_i, addr_i, wr_data_i, be_i,
      input  ready_o, rd_valid_o, rd_data_o, err_o
   );

   modport slave (
      input  valid_i, wr_rd_i, addr_i, wr_data_i, be_i,
      output ready_o, rd_valid_o, rd_data_o, err_o
   );
endinterface

// File: rtl/mem_multi_port.sv
// Single-port word memory shared by NUM_CH valid/ready channels through a
// round-robin arbiter, with byte enables, RD_LAT read pipeline and range errors.
module mem_multi_port #(
   parameter int WIDTH      = 16,
   parameter int DEPTH      = 64,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int NUM_CH     = 2,
   parameter int RD_LAT     = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   mem_multi_port_if.slave bus
);
   localparam int          NB     = WIDTH / 8;
   localparam int unsigned NBU    = NB;
   localparam int unsigned NCH    = NUM_CH;
   localparam int unsigned LATU   = RD_LAT;
   localparam int          CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef struct packed {
      logic             vld;
      logic             rd;
      logic             err;
      logic [CH_W-1:0]  ch;
      logic [WIDTH-1:0] data;
   } ret_t;

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [CH_W-1:0]       ptr_q;
   logic [CH_W-1:0]       gnt_ch;
   logic [NUM_CH-1:0]     grant;
   logic                  found;
   logic                  hs;
   logic                  sel_wr;
   logic                  oob;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [WIDTH-1:0]      sel_wdata;
   logic [NB-1:0]         sel_be;
   ret_t                  ret_d;
   ret_t                  pipe_q [RD_LAT];
   ret_t                  tail;
   logic [WIDTH-1:0]      hold_q [NUM_CH];

   // Two passes give the wrap-around search: channels above the pointer first,
   // then from channel 0 up to and including the pointer.
   always_comb begin
      grant  = '0;
      gnt_ch = '0;
      found  = 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (!found && bus.valid_i[i] && (i > 32'(ptr_q))) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            gnt_ch   = CH_W'(i);
         end
      end
      for (int unsigned i = 0; i < NCH; i++) begin
         if (!found && bus.valid_i[i] && (i <= 32'(ptr_q))) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            gnt_ch   = CH_W'(i);
         end
      end
   end

   assign hs          = found & rst_i;
   assign bus.ready_o = rst_i ? grant : '0;

   always_comb begin
      sel_wr    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_be    = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         if (grant[c]) begin
            sel_wr    = bus.wr_rd_i[c];
            sel_addr  = bus.addr_i[c*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = bus.wr_data_i[c*WIDTH +: WIDTH];
            sel_be    = bus.be_i[c*NB +: NB];
         end
      end
   end

   assign oob = (32'(sel_addr) >= 32'(DEPTH));

   // Writes to out-of-range addresses still produce a return slot so err_o
   // lines up at RD_LAT; only reads raise rd_valid_o.
   always_comb begin
      ret_d      = '0;
      ret_d.vld  = hs & (~sel_wr | oob);
      ret_d.rd   = ~sel_wr;
      ret_d.err  = oob;
      ret_d.ch   = gnt_ch;
      if (!sel_wr && !oob) begin
         ret_d.data = mem[sel_addr];
      end
   end

   always_ff @(posedge clk_i) begin
      if (hs && sel_wr && !oob) begin
         for (int unsigned b = 0; b < NBU; b++) begin
            if (sel_be[b]) begin
               mem[sel_addr][b*8 +: 8] <= sel_wdata[b*8 +: 8];
            end
         end
      end
   end

   assign tail = pipe_q[RD_LAT-1];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ptr_q <= CH_W'(NUM_CH - 1);
         for (int unsigned i = 0; i < LATU; i++) begin
            pipe_q[i] <= '0;
         end
         for (int unsigned c = 0; c < NCH; c++) begin
            hold_q[c] <= '0;
         end
      end else begin
         if (hs) begin
            ptr_q <= gnt_ch;
         end
         pipe_q[0] <= ret_d;
         for (int unsigned i = 1; i < LATU; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
         for (int unsigned c = 0; c < NCH; c++) begin
            if (tail.vld && tail.rd && (tail.ch == CH_W'(c))) begin
               hold_q[c] <= tail.data;
            end
         end
      end
   end

   always_comb begin
      logic hit;
      bus.rd_valid_o = '0;
      bus.err_o      = '0;
      bus.rd_data_o  = '0;
      hit            = 1'b0;
      for (int unsigned c = 0; c < NCH; c++) begin
         hit               = tail.vld && (tail.ch == CH_W'(c));
         bus.rd_valid_o[c] = hit && tail.rd;
         bus.err_o[c]      = hit && tail.err;
         bus.rd_data_o[c*WIDTH +: WIDTH] = (hit && tail.rd) ? tail.data : hold_q[c];
      end
   end
endmodule

// File: tb/tb_mem_multi_port.sv
// Bench for mem_multi_port: three instances (RD_LAT 1/3/4, DEPTH 48, 2 channels)
// share directed stimulus and are checked every cycle against an event model.
module tb_mem_multi_port;
   localparam int W  = 16;
   localparam int D  = 48;
   localparam int AW = 6;
   localparam int NC = 2;

   logic        clk   = 1'b0;
   logic        rst   = 1'b0;
   logic [1:0]  valid = '0;
   logic [1:0]  wr    = '0;
   logic [11:0] addr  = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  be    = '0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_multi_port_if #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_CH(NC)) if_a ();
   mem_multi_port_if #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_CH(NC)) if_b ();
   mem_multi_port_if #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_CH(NC)) if_c ();

   assign if_a.valid_i = valid;  assign if_b.valid_i = valid;  assign if_c.valid_i = valid;
   assign if_a.wr_rd_i = wr;     assign if_b.wr_rd_i = wr;     assign if_c.wr_rd_i = wr;
   assign if_a.addr_i  = addr;   assign if_b.addr_i  = addr;   assign if_c.addr_i  = addr;
   assign if_a.wr_data_i = wdata; assign if_b.wr_data_i = wdata; assign if_c.wr_data_i = wdata;
   assign if_a.be_i    = be;     assign if_b.be_i    = be;     assign if_c.be_i    = be;

   mem_multi_port #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .NUM_CH(NC), .RD_LAT(1))
      u_lat1 (.clk_i(clk), .rst_i(rst), .bus(if_a));
   mem_multi_port #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .NUM_CH(NC), .RD_LAT(3))
      u_lat3 (.clk_i(clk), .rst_i(rst), .bus(if_b));
   mem_multi_port #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .NUM_CH(NC), .RD_LAT(4))
      u_lat4 (.clk_i(clk), .rst_i(rst), .bus(if_c));

   logic [1:0]  rdy_w [3];
   logic [1:0]  rv_w  [3];
   logic [1:0]  err_w [3];
   logic [31:0] rd_w  [3];
   assign rdy_w[0] = if_a.ready_o;    assign rdy_w[1] = if_b.ready_o;    assign rdy_w[2] = if_c.ready_o;
   assign rv_w[0]  = if_a.rd_valid_o; assign rv_w[1]  = if_b.rd_valid_o; assign rv_w[2]  = if_c.rd_valid_o;
   assign err_w[0] = if_a.err_o;      assign err_w[1] = if_b.err_o;      assign err_w[2] = if_c.err_o;
   assign rd_w[0]  = if_a.rd_data_o;  assign rd_w[1]  = if_b.rd_data_o;  assign rd_w[2]  = if_c.rd_data_o;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: every handshake becomes an event stamped with its clock edge; an
   // instance of latency L shows the event of edge E-L+1 after edge E.
   int          lat_t [3] = '{1, 3, 4};
   logic [15:0] mem_m [D];
   int          ptr_m = NC - 1;
   bit          ev_v   [1024];
   bit          ev_rd  [1024];
   bit          ev_err [1024];
   int          ev_ch  [1024];
   logic [15:0] ev_d   [1024];
   logic [15:0] hold_m [3][2];
   int unsigned edge_n = 0;

   always @(posedge clk) edge_n <= edge_n + 1;

   always @(negedge clk) begin : model
      logic [1:0]  e_rv, e_err, e_rdy;
      logic [31:0] e_rd;
      logic [15:0] d;
      int          h, c, gc, a, nx;
      bit          found;
      for (int k = 0; k < 3; k++) begin
         e_rv  = '0;
         e_err = '0;
         if (!rst) begin
            hold_m[k][0] = '0;
            hold_m[k][1] = '0;
         end else begin
            h = int'(edge_n) - lat_t[k] + 1;
            if (h >= 0 && ev_v[h]) begin
               c = ev_ch[h];
               if (ev_rd[h]) begin
                  e_rv[c]      = 1'b1;
                  hold_m[k][c] = ev_d[h];
               end
               if (ev_err[h]) e_err[c] = 1'b1;
            end
         end
         e_rd = {hold_m[k][1], hold_m[k][0]};
         chk($sformatf("rd_valid_L%0d", lat_t[k]), 32'(rv_w[k]), 32'(e_rv));
         chk($sformatf("err_L%0d", lat_t[k]), 32'(err_w[k]), 32'(e_err));
         chk($sformatf("rd_data_L%0d", lat_t[k]), rd_w[k], e_rd);
      end
      if (!rst) begin
         ptr_m = NC - 1;
         for (int i = 0; i < 1024; i++) ev_v[i] = 1'b0;
      end
      e_rdy = '0;
      found = 1'b0;
      gc    = 0;
      if (rst) begin
         for (int k = 1; k <= NC; k++) begin
            c = (ptr_m + k) % NC;
            if (!found && valid[c]) begin
               found = 1'b1;
               gc    = c;
            end
         end
         if (found) e_rdy[gc] = 1'b1;
      end
      for (int k = 0; k < 3; k++)
         chk($sformatf("ready_L%0d", lat_t[k]), 32'(rdy_w[k]), 32'(e_rdy));
      if (found) begin
         nx = int'(edge_n) + 1;
         a  = int'(addr[gc*AW +: AW]);
         d  = wdata[gc*W +: W];
         ev_ch[nx]  = gc;
         ev_rd[nx]  = !wr[gc];
         ev_err[nx] = (a >= D);
         ev_v[nx]   = !wr[gc] || (a >= D);
         ev_d[nx]   = (wr[gc] || a >= D) ? 16'h0000 : mem_m[a];
         if (wr[gc] && a < D) begin
            for (int b = 0; b < 2; b++)
               if (be[gc*2 + b]) mem_m[a][b*8 +: 8] = d[b*8 +: 8];
         end
         ptr_m = gc;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [1:0] v, input logic [1:0] w, input int a0, input int a1,
                      input logic [15:0] d0, input logic [15:0] d1,
                      input logic [1:0] b0, input logic [1:0] b1);
      valid = v;
      wr    = w;
      addr  = {6'(a1), 6'(a0)};
      wdata = {d1, d0};
      be    = {b1, b0};
   endtask

   task automatic idle();
      req(2'b00, 2'b00, 0, 0, 16'h0, 16'h0, 2'b00, 2'b00);
   endtask

   logic [1:0] alt_seq [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

   initial begin
      // Reset with both channels requesting writes of addresses 0 and 1.
      req(2'b11, 2'b11, 0, 1, 16'hC000, 16'hC001, 2'b11, 2'b11);
      repeat (3) step();
      chk("lit_reset_ready", 32'(rdy_w[0]), 32'h0);
      chk("lit_reset_rd_data", rd_w[2], 32'h0);
      rst = 1'b1;
      #1;
      chk("lit_first_grant", 32'(rdy_w[0]), 32'h1);
      step();
      step();
      for (int a = 2; a < D; a++) begin
         req(2'b01, 2'b01, a, 0, 16'hC000 + 16'(a), 16'h0, 2'b11, 2'b00);
         step();
      end

      req(2'b01, 2'b01, 5, 0, 16'hA5A5, 16'h0, 2'b11, 2'b00);
      step();
      req(2'b01, 2'b00, 5, 0, 16'h0, 16'h0, 2'b00, 2'b00);
      step();
      chk("lit_rd5_valid", 32'(rv_w[0]), 32'h1);
      chk("lit_rd5_data", 32'(rd_w[0][15:0]), 32'hA5A5);
      idle();
      step();

      // Leave the pointer on channel 1 so alternation starts with channel 0.
      req(2'b10, 2'b10, 0, 20, 16'h0, 16'h1111, 2'b00, 2'b11);
      step();
      req(2'b11, 2'b00, 10, 20, 16'h0, 16'h0, 2'b00, 2'b00);
      for (int i = 0; i < 6; i++) begin
         #1;
         chk($sformatf("lit_alt_grant%0d", i), 32'(rdy_w[0]), 32'(alt_seq[i]));
         step();
      end
      chk("lit_alt_L3_valid", 32'(rv_w[1]), 32'h2);
      chk("lit_alt_L3_data", 32'(rd_w[1][31:16]), 32'h1111);
      idle();
      step();

      req(2'b01, 2'b01, 9, 0, 16'h1234, 16'h0, 2'b11, 2'b00);
      step();
      req(2'b01, 2'b01, 9, 0, 16'hFFFF, 16'h0, 2'b10, 2'b00);
      step();
      req(2'b01, 2'b00, 9, 0, 16'h0, 16'h0, 2'b00, 2'b00);
      step();
      chk("lit_byte_merge", 32'(rd_w[0][15:0]), 32'hFF34);
      idle();
      step();

      req(2'b10, 2'b00, 0, 50, 16'h0, 16'h0, 2'b00, 2'b00);
      step();
      chk("lit_oob_rd_valid", 32'(rv_w[0]), 32'h2);
      chk("lit_oob_rd_err", 32'(err_w[0]), 32'h2);
      chk("lit_oob_rd_data", 32'(rd_w[0][31:16]), 32'h0);
      req(2'b10, 2'b10, 0, 50, 16'h0, 16'hBEEF, 2'b00, 2'b11);
      step();
      chk("lit_oob_wr_err", 32'(err_w[0]), 32'h2);
      chk("lit_oob_wr_novalid", 32'(rv_w[0]), 32'h0);
      req(2'b10, 2'b00, 0, 2, 16'h0, 16'h0, 2'b00, 2'b00);
      step();
      chk("lit_alias_intact", 32'(rd_w[0][31:16]), 32'hC002);
      idle();
      step();

      // Reset lands while the RD_LAT=4 return is still in flight.
      req(2'b01, 2'b00, 9, 0, 16'h0, 16'h0, 2'b00, 2'b00);
      step();
      idle();
      step();
      step();
      rst = 1'b0;
      #1;
      chk("lit_midrst_L4_valid", 32'(rv_w[2]), 32'h0);
      step();
      rst = 1'b1;
      repeat (4) step();
      chk("lit_postrst_L4_data", rd_w[2], 32'h0);
      req(2'b01, 2'b00, 9, 0, 16'h0, 16'h0, 2'b00, 2'b00);
      step();
      idle();
      repeat (3) step();
      chk("lit_reread_L4_valid", 32'(rv_w[2]), 32'h1);
      chk("lit_reread_L4_data", 32'(rd_w[2][15:0]), 32'hFF34);
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_multi_port.md
Name: mem_multi_port

Overview:
- Parametrised successor to the team's single-channel valid/ready memory model.
- One shared single-port storage array is served to NUM_CH independent request channels through a round-robin arbiter.
- Adds per-byte write enables, a configurable read pipeline latency, per-channel read-return valids, and out-of-range error reporting.
- Serves as the DUT for the next-generation memory testbench; each channel is driven by its own BFM instance.

Parameters:
- WIDTH, 16, data word width in bits; must be a multiple of 8.
- DEPTH, 64, number of words; need not be a power of 2.
- ADDR_WIDTH, $clog2(DEPTH), address width per channel.
- NUM_CH, 2, number of request channels, 1..8.
- RD_LAT, 1, cycles from read handshake to rd_valid_o, 1..4.

Ports:
- clk_i  input  1  clock; all logic on posedge.
- rst_i  input  1  asynchronous, active-low reset.
- valid_i  input  NUM_CH  per-channel request valid.
- wr_rd_i  input  NUM_CH  per-channel op: 1 = write, 0 = read.
- addr_i  input  NUM_CH*ADDR_WIDTH  channel c address at bits [c*ADDR_WIDTH +: ADDR_WIDTH].
- wr_data_i  input  NUM_CH*WIDTH  channel c write data at [c*WIDTH +: WIDTH].
- be_i  input  NUM_CH*(WIDTH/8)  channel c byte enables; bit b writes byte b.
- ready_o  output  NUM_CH  grant; a transfer occurs on channel c when valid_i[c] & ready_o[c] at a posedge.
- rd_valid_o  output  NUM_CH  one-cycle pulse: read data for channel c is present.
- rd_data_o  output  NUM_CH*WIDTH  read data for channel c; holds its last value when not valid.
- err_o  output  NUM_CH  one-cycle pulse, RD_LAT cycles after a handshake whose address >= DEPTH.

Behaviour:
- Reset (rst_i low, asynchronous):
  - ready_o = 0, rd_valid_o = 0, rd_data_o = 0, err_o = 0.
  - Arbiter pointer = NUM_CH-1, so channel 0 has first priority.
  - Read pipeline valids are cleared.
  - Memory array is NOT reset; contents survive reset.
- Arbitration:
  - ready_o is combinational and one-hot or zero.
  - Grant goes to the first requesting channel searching from pointer+1 upward with wrap-around.
  - ready_o[c] = 1 only if valid_i[c] = 1; all ready_o = 0 when no channel requests.
  - Pointer updates to the granted channel only on a handshake cycle.
  - Exactly one access per cycle.
  - Request fields must stay stable while valid_i is high and not granted.
  - Deasserting valid_i before a grant is legal; the request is simply withdrawn.
- Write:
  - Commits at the handshake edge: byte b of mem[addr] <= wr_data byte b where be bit b = 1.
  - be = 0 still handshakes with no state change.
  - No read response or rd_valid_o for writes.
- Read:
  - Address and channel ID are captured at the handshake edge.
  - rd_valid_o[ch] pulses exactly RD_LAT cycles later, with rd_data_o[ch] = mem[addr] as of the handshake edge.
  - Back-to-back reads are fully pipelined: one return per cycle, in handshake order.
  - Different channels' returns never collide because at most one handshake occurs per cycle.
- Ordering:
  - A write to address A at cycle t followed by a read of A at cycle t+1 or later returns the new data.
  - A read at cycle t followed by a write at t+1 returns the old data.
- Out-of-range (addr >= DEPTH, possible only when DEPTH is not a power of 2):
  - Handshake still occurs; a write is dropped.
  - For a read, rd_valid_o pulses with rd_data_o = 0.
  - err_o[ch] pulses at the same latency (RD_LAT) for both reads and writes.
- Reset mid-operation:
  - All in-flight read returns are discarded; no rd_valid_o appears after reset release for pre-reset requests.
  - The first grant after release goes to channel 0 if it is requesting.
- NUM_CH = 1: arbiter degenerates to ready_o = valid_i.

Test Plan:
- Reset, NUM_CH=2: hold rst_i=0 with valid_i=2'b11 -> ready_o=0, rd_valid_o=0, rd_data_o=0, err_o=0; after release, first grant is ready_o=2'b01.
- Ch0 writes 16'hA5A5 to addr 5 with be=2'b11, then reads addr 5, RD_LAT=1 -> rd_valid_o[0] pulses one cycle after the read handshake with rd_data_o[15:0]=16'hA5A5; rd_valid_o[1] stays 0.
- Both channels hold valid_i for reads for 6 cycles -> grants alternate 01,10,01,10,01,10; with RD_LAT=3, returns arrive 3 cycles after each grant on the matching channel.
- Write 16'h1234 to addr 9 with be=2'b11, then 16'hFFFF with be=2'b10, then read -> 16'hFF34.
- DEPTH=48: ch1 reads addr 50 -> rd_valid_o[1] and err_o[1] pulse after RD_LAT with data 0; ch1 writes addr 50, then reads addr 50-48=2 -> addr 2 content unchanged.
- RD_LAT=4: issue a read, assert rst_i=0 two cycles later for one cycle -> no rd_valid_o at any cycle; memory contents are intact on a re-read.
